// File: rtl/contador_updown_param_if.sv
// Control/status bundle for the parametrised up/down counter.
// The master side drives the requests; the slave side (the counter) returns the count and flags.
interface contador_updown_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic             acrescer;
   logic             decrecer;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] saida;
   logic             ovf;
   logic             unf;
   logic             at_max;
   logic             at_min;

   modport master (
      output en, acrescer, decrecer, load, load_val,
      input  saida, ovf, unf, at_max, at_min
   );

   modport slave (
      input  en, acrescer, decrecer, load, load_val,
      output saida, ovf, unf, at_max, at_min
   );
endinterface

// File: rtl/contador_updown_param.sv
// Parametrised up/down counter with wrap or saturate at [MIN_VAL, MAX_VAL].
// Priority: reset > load > count > hold. All arithmetic is done one bit wider than
// the count so that bound crossings are detected explicitly, never by native wrap.
module contador_updown_param #(
   parameter int unsigned     WIDTH     = 8,
   parameter longint unsigned RESET_VAL = 106,
   parameter longint unsigned MIN_VAL   = 0,
   parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
   parameter longint unsigned STEP      = 1,
   parameter bit              SATURATE  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   contador_updown_param_if.slave  bus
);

   localparam logic [WIDTH:0]   MIN_W   = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
   // Size of the count range; MAX_VAL-MIN_VAL+1 never exceeds 2**WIDTH, so it fits.
   localparam logic [WIDTH:0]   RANGE_W = MAX_W - MIN_W + 1'b1;
   // Smallest value from which a plain decrement stays in range.
   localparam logic [WIDTH:0]   DEC_LIM = MIN_W + STEP_W;
   localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);

   logic [WIDTH:0]   cur;
   logic [WIDTH:0]   lv;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] nxt;
   logic             nxt_ovf;
   logic             nxt_unf;

   // Next count and event flags: load clamps, count wraps or saturates at the bounds.
   always_comb begin
      cur     = {1'b0, bus.saida};
      lv      = {1'b0, bus.load_val};
      sum     = cur + STEP_W;
      nxt     = bus.saida;
      nxt_ovf = 1'b0;
      nxt_unf = 1'b0;
      if (bus.load) begin
         if (lv < MIN_W)      nxt = MIN_V;
         else if (lv > MAX_W) nxt = MAX_V;
         else                 nxt = bus.load_val;
      end else if (bus.en && (bus.acrescer ^ bus.decrecer)) begin
         if (bus.acrescer) begin
            if (sum <= MAX_W) begin
               nxt = WIDTH'(sum);
            end else begin
               nxt_ovf = 1'b1;
               nxt     = SATURATE ? MAX_V : WIDTH'(sum - RANGE_W);
            end
         end else begin
            if (cur >= DEC_LIM) begin
               nxt = WIDTH'(cur - STEP_W);
            end else begin
               nxt_unf = 1'b1;
               nxt     = SATURATE ? MIN_V : WIDTH'(cur + RANGE_W - STEP_W);
            end
         end
      end
   end

   // Count and event-pulse registers; synchronous reset drops any pending request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.saida <= RST_V;
         bus.ovf   <= 1'b0;
         bus.unf   <= 1'b0;
      end else begin
         bus.saida <= nxt;
         bus.ovf   <= nxt_ovf;
         bus.unf   <= nxt_unf;
      end
   end

   assign bus.at_max = (bus.saida == MAX_V);
   assign bus.at_min = (bus.saida == MIN_V);

endmodule

// File: tb/tb_contador_updown_param.sv
// Directed bench: default counter, saturating 10..20 step 3, wrapping 10..20 step 3.
module tb_contador_updown_param;

   logic clk = 1'b0;
   logic rst_n;
   int   errs   = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   contador_updown_param_if #(.WIDTH(8)) b_def ();
   contador_updown_param_if #(.WIDTH(8)) b_sat ();
   contador_updown_param_if #(.WIDTH(8)) b_wrp ();

   contador_updown_param #(.WIDTH(8)) u_def (
      .clk(clk), .rst_n(rst_n), .bus(b_def.slave));

   contador_updown_param #(.WIDTH(8), .RESET_VAL(15), .MIN_VAL(10), .MAX_VAL(20),
                           .STEP(3), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(b_sat.slave));

   contador_updown_param #(.WIDTH(8), .RESET_VAL(15), .MIN_VAL(10), .MAX_VAL(20),
                           .STEP(3), .SATURATE(1'b0)) u_wrp (
      .clk(clk), .rst_n(rst_n), .bus(b_wrp.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock and sample away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      b_def.en = 0; b_def.acrescer = 0; b_def.decrecer = 0; b_def.load = 0; b_def.load_val = '0;
      b_sat.en = 0; b_sat.acrescer = 0; b_sat.decrecer = 0; b_sat.load = 0; b_sat.load_val = '0;
      b_wrp.en = 0; b_wrp.acrescer = 0; b_wrp.decrecer = 0; b_wrp.load = 0; b_wrp.load_val = '0;

      // 1: reset, count up 3, hold on both requests
      tick(); tick();
      chk("rst_def_saida", b_def.saida, 106);
      chk("rst_def_ovf", b_def.ovf, 0);
      chk("rst_def_unf", b_def.unf, 0);
      chk("rst_sat_saida", b_sat.saida, 15);
      rst_n = 1'b1;
      b_def.en = 1; b_def.acrescer = 1;
      tick(); chk("inc1", b_def.saida, 107);
      tick(); tick();
      chk("inc3", b_def.saida, 109);
      b_def.decrecer = 1;
      tick();
      chk("both_hold", b_def.saida, 109);
      chk("both_ovf", b_def.ovf, 0);
      chk("both_unf", b_def.unf, 0);

      // 2: load 254, count to 255 then wrap to 0
      b_def.acrescer = 0; b_def.decrecer = 0;
      b_def.load = 1; b_def.load_val = 8'd254;
      tick(); chk("load254", b_def.saida, 254);
      b_def.load = 0; b_def.acrescer = 1;
      tick();
      chk("to255", b_def.saida, 255);
      chk("at_max255", b_def.at_max, 1);
      chk("ovf_not_yet", b_def.ovf, 0);
      tick();
      chk("wrap0", b_def.saida, 0);
      chk("wrap_ovf", b_def.ovf, 1);
      chk("at_min0", b_def.at_min, 1);
      b_def.acrescer = 0;
      tick();
      chk("ovf_clear", b_def.ovf, 0);
      chk("hold0", b_def.saida, 0);

      // 3: saturating range 10..20, step 3
      b_sat.load = 1; b_sat.load_val = 8'd19;
      tick(); chk("sat_load19", b_sat.saida, 19);
      b_sat.load = 0; b_sat.en = 1; b_sat.acrescer = 1;
      tick();
      chk("sat_clamp20", b_sat.saida, 20);
      chk("sat_ovf1", b_sat.ovf, 1);
      chk("sat_at_max", b_sat.at_max, 1);
      tick();
      chk("sat_stay20", b_sat.saida, 20);
      chk("sat_ovf2", b_sat.ovf, 1);
      b_sat.acrescer = 0;
      tick();
      chk("sat_idle", b_sat.saida, 20);
      chk("sat_ovf_clr", b_sat.ovf, 0);
      b_sat.load = 1; b_sat.load_val = 8'd10;
      tick();
      b_sat.load = 0; b_sat.decrecer = 1;
      tick();
      chk("sat_min10", b_sat.saida, 10);
      chk("sat_unf", b_sat.unf, 1);
      chk("sat_unf_noovf", b_sat.ovf, 0);
      b_sat.decrecer = 0; b_sat.en = 0;

      // 4: wrapping range 10..20, step 3
      b_wrp.load = 1; b_wrp.load_val = 8'd11;
      tick(); chk("wrp_load11", b_wrp.saida, 11);
      b_wrp.load = 0; b_wrp.en = 1; b_wrp.decrecer = 1;
      tick();
      chk("wrp_dec19", b_wrp.saida, 19);
      chk("wrp_unf", b_wrp.unf, 1);
      b_wrp.decrecer = 0; b_wrp.acrescer = 1;
      tick();
      chk("wrp_inc11", b_wrp.saida, 11);
      chk("wrp_ovf", b_wrp.ovf, 1);
      chk("wrp_unf_clr", b_wrp.unf, 0);
      b_wrp.acrescer = 0; b_wrp.en = 0;

      // 5: en gating, load ignores en, load clamping
      b_def.en = 0; b_def.acrescer = 1;
      tick(); tick(); tick(); tick();
      chk("en0_hold", b_def.saida, 0);
      chk("en0_noovf", b_def.ovf, 0);
      b_def.acrescer = 0; b_def.load = 1; b_def.load_val = 8'd50;
      tick(); chk("load50_en0", b_def.saida, 50);
      b_sat.load = 1; b_sat.load_val = 8'd5;
      tick();
      chk("clamp_lo", b_sat.saida, 10);
      chk("clamp_lo_atmin", b_sat.at_min, 1);
      b_sat.load_val = 8'd30;
      tick();
      chk("clamp_hi", b_sat.saida, 20);
      chk("clamp_hi_flags", {b_sat.ovf, b_sat.unf}, 0);
      b_sat.load = 0;

      // 6: reset beats load and count in the same cycle
      b_def.load_val = 8'd120;
      tick(); chk("load120", b_def.saida, 120);
      b_def.en = 1; b_def.acrescer = 1; b_def.load_val = 8'd7; rst_n = 1'b0;
      tick();
      chk("rst_wins", b_def.saida, 106);
      chk("rst_wins_flags", {b_def.ovf, b_def.unf}, 0);
      rst_n = 1'b1; b_def.load = 0;
      tick();
      chk("resume107", b_def.saida, 107);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/contador_updown_param.md
Name: contador_updown_param

Overview:
Parametrised up/down counter, next generation of the team's 8-bit up/down counter. Adds:
- configurable width, reset value, bounds and step;
- wrap or saturate mode;
- synchronous parallel load and count enable;
- registered overflow/underflow event pulses and bound flags.

It is used as a general event/position counter in datapath and control blocks. With default parameters it behaves exactly like the legacy counter: reset to 106, +1/-1, wraps at 8 bits.

Parameters:
- WIDTH, 8, counter width in bits (2..32)
- RESET_VAL, 106, value loaded on reset; MIN_VAL <= RESET_VAL <= MAX_VAL
- MIN_VAL, 0, lower bound of count range
- MAX_VAL, 2**WIDTH-1, upper bound of count range; MIN_VAL < MAX_VAL < 2**WIDTH
- STEP, 1, increment/decrement amount; 1 <= STEP <= MAX_VAL-MIN_VAL
- SATURATE, 0, 0 = modular wrap within [MIN_VAL, MAX_VAL]; 1 = clamp at bounds

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  count enable; gates acrescer/decrecer only
- acrescer  in  1  increment request
- decrecer  in  1  decrement request
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- saida  out  WIDTH  counter value, registered
- ovf  out  1  one-cycle pulse: last increment crossed MAX_VAL
- unf  out  1  one-cycle pulse: last decrement crossed MIN_VAL
- at_max  out  1  saida == MAX_VAL (decoded from register)
- at_min  out  1  saida == MIN_VAL (decoded from register)

Behaviour:
- All state updates on the rising edge of clk. Priority order: reset > load > count > hold.
- Reset (rst_n=0): saida=RESET_VAL, ovf=0, unf=0. Reset wins over load and count in the same cycle.
- Load:
  - load=1 (rst_n=1): saida = load_val clamped into [MIN_VAL, MAX_VAL]; below MIN_VAL -> MIN_VAL, above MAX_VAL -> MAX_VAL.
  - Independent of en. ovf=unf=0 on that cycle.
- Count:
  - Only when en=1 and load=0.
  - acrescer=1, decrecer=0 -> increment. acrescer=0, decrecer=1 -> decrement.
  - Both 1 or both 0 -> hold, flags 0.
- Arithmetic: done at WIDTH+1 bits, so there is no silent native wrap.
  - Increment: if saida+STEP <= MAX_VAL, saida += STEP, else overflow.
  - Decrement: if saida-STEP >= MIN_VAL (evaluated without underflow), saida -= STEP, else underflow.
- Overflow, wrap mode (SATURATE=0): saida = saida+STEP-(MAX_VAL-MIN_VAL+1), ovf=1 for that cycle.
- Underflow, wrap mode: saida = saida-STEP+(MAX_VAL-MIN_VAL+1), unf=1.
- Overflow, saturate mode (SATURATE=1): saida = MAX_VAL, ovf=1. This includes an increment requested while already at MAX_VAL.
- Underflow, saturate mode: saida = MIN_VAL, unf=1. This includes a decrement requested while already at MIN_VAL.
- Flag timing:
  - ovf/unf are registered and appear in the same cycle the new saida appears; at most one is high.
  - ovf/unf clear on the next cycle unless re-triggered.
  - at_max/at_min are combinational decodes of the saida register, with no added latency.
- Latency: one clock from request to new saida. No internal state beyond saida, ovf and unf.
- Reset mid-operation: any pending request is discarded; no flag is produced.

Test Plan:
1. Defaults; rst_n=0 for 2 cycles -> saida=106. en=1, acrescer=1 for 3 cycles -> 109. acrescer=decrecer=1 -> holds 109, ovf=unf=0.
2. Defaults; load=1, load_val=254; then acrescer for 2 cycles -> 255 (at_max=1), then 0 with ovf=1 for exactly one cycle, at_min=1.
3. SATURATE=1, MIN_VAL=10, MAX_VAL=20, STEP=3; load 19, increment -> 20 with ovf=1; increment again -> 20 with ovf=1; idle -> ovf=0.
4. SATURATE=0, MIN_VAL=10, MAX_VAL=20, STEP=3; load 11, decrement -> 19 (11-3+11) with unf=1; increment from 19 -> 11 with ovf=1.
5. en=0 with acrescer=1 for 4 cycles -> saida unchanged. load=1, load_val=50 with en=0 -> 50. MIN_VAL=10 config with load_val=5 -> 10; load_val=30 with MAX_VAL=20 -> 20.
6. Counting at 120 with load=1, load_val=7 and rst_n=0 in the same cycle -> saida=106, ovf=unf=0; normal counting resumes from 106 next cycle.
